// File: rtl/ror_seq.sv
// Sequential rotate unit: rotates an operand one bit per clock under a start/done handshake.
// Result is registered and held until the next completed operation.
module ror_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic             direction,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

    // Single-position rotate; left moves the MSB into bit 0, right moves bit 0 into the MSB.
    function automatic logic [WIDTH-1:0] rotate_one(input logic [WIDTH-1:0] value,
                                                    input logic             left);
        logic [WIDTH-1:0] r;
        if (left) begin
            r = {value[WIDTH-2:0], value[WIDTH-1]};
        end else begin
            r = {value[0], value[WIDTH-1:1]};
        end
        return r;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] work_r;
    logic [AMT_W-1:0] cnt_r;
    logic             dir_r;
    logic [WIDTH-1:0] y_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] rot_s;

    // Next rotated value of the working register.
    always_comb begin
        rot_s = rotate_one(work_r, dir_r);
    end

    // Control FSM with registered busy/done so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            work_r  <= WORD_ZERO;
            cnt_r   <= CNT_ZERO;
            dir_r   <= 1'b0;
            y_r     <= WORD_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts exactly like IDLE, giving back-to-back operation.
                    if (start) begin
                        work_r <= a;
                        cnt_r  <= amt;
                        dir_r  <= direction;
                        if (amt == CNT_ZERO) begin
                            y_r     <= a;
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_SHIFT;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work_r <= rot_s;
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        y_r     <= rot_s;
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
